// File: rtl/ram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_cmd_arbiter
// Purpose  : Two-requester round-robin arbiter that serialises word transactions
//            into the RAM's 2-bit-opcode command stream and returns read data.
// Option   : ARB_ADDR_CACHE_EN - skip address commands that repeat the last one
// Revision : 1.0 - initial release
// ============================================================================
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int NUM_REQ   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_wr,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [ADDR_SIZE-1:0]         rsp_rdata,
    output logic [ADDR_SIZE+1:0]         ram_din,
    output logic                         ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]         ram_dout,
    input  logic                         ram_tx_valid,
    output logic                         protocol_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        RADDR = 3'd3,
        RCMD  = 3'd4,
        RWAIT = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  ptr;
    logic                  owner;
    logic [ADDR_SIZE-1:0]  cur_addr;
    logic [ADDR_SIZE-1:0]  cur_wdata;
    logic [NUM_REQ-1:0]    grant;
    logic                  sel;
    logic                  sel_wr;
    logic [ADDR_SIZE-1:0]  sel_addr;
    logic [ADDR_SIZE-1:0]  sel_wdata;
    logic                  accept;
    logic                  wr_hit;
    logic                  rd_hit;

    // A lone requester always wins; on contention the pointer side wins.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
        sel       = grant[1];
        sel_wr    = sel ? req_wr[1] : req_wr[0];
        sel_addr  = sel ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE]  : req_addr[ADDR_SIZE-1:0];
        sel_wdata = sel ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE] : req_wdata[ADDR_SIZE-1:0];
        req_ready = (rst_n && (state == IDLE)) ? grant : '0;
        accept    = |req_ready;
    end

`ifdef ARB_ADDR_CACHE_EN
    logic [ADDR_SIZE-1:0] last_wr_addr;
    logic [ADDR_SIZE-1:0] last_rd_addr;
    logic                 last_wr_vld;
    logic                 last_rd_vld;

    // Mirrors the RAM's address registers, which share the same reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_addr <= '0;
            last_rd_addr <= '0;
            last_wr_vld  <= 1'b0;
            last_rd_vld  <= 1'b0;
        end else begin
            if (state == WADDR) begin
                last_wr_addr <= cur_addr;
                last_wr_vld  <= 1'b1;
            end
            if (state == RADDR) begin
                last_rd_addr <= cur_addr;
                last_rd_vld  <= 1'b1;
            end
        end
    end

    assign wr_hit = last_wr_vld && (last_wr_addr == sel_addr);
    assign rd_hit = last_rd_vld && (last_rd_addr == sel_addr);
`else
    assign wr_hit = 1'b0;
    assign rd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ram_rx_valid = 1'b0;
        ram_din      = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_wr) begin
                        state_nxt = wr_hit ? WDATA : WADDR;
                    end else begin
                        state_nxt = rd_hit ? RCMD : RADDR;
                    end
                end
            end
            WADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {2'b00, cur_addr};
                state_nxt    = WDATA;
            end
            WDATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = {2'b01, cur_wdata};
                state_nxt    = IDLE;
            end
            RADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {2'b10, cur_addr};
                state_nxt    = RCMD;
            end
            RCMD: begin
                ram_rx_valid = 1'b1;
                ram_din      = {2'b11, {ADDR_SIZE{1'b0}}};
                state_nxt    = RWAIT;
            end
            RWAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= 1'b0;
            owner        <= 1'b0;
            cur_addr     <= '0;
            cur_wdata    <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            protocol_err <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                ptr       <= ~sel;
                owner     <= sel;
                cur_addr  <= sel_addr;
                cur_wdata <= sel_wdata;
            end
            // Missing RAM valid is flagged, but the response still goes out.
            if (state == RWAIT) begin
                rsp_rdata        <= ram_dout;
                rsp_valid[owner] <= 1'b1;
                if (!ram_tx_valid) begin
                    protocol_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_cmd_arbiter
// Purpose  : Directed self-checking bench for ram_cmd_arbiter with a RAM model
//            and a transaction-level reference model (ARB_ADDR_CACHE_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_cmd_arbiter;

`ifdef ARB_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic [7:0]  ram_dout;
    logic        ram_tx_valid;
    logic        protocol_err;
    bit          suppress_tx = 1'b0;

    always #5 clk = ~clk;

    ram_cmd_arbiter #(.ADDR_SIZE(8), .NUM_REQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .protocol_err(protocol_err)
    );

    // RAM: read data appears the cycle after the 11 command.
    logic [7:0] ram_mem [256];
    logic [7:0] ram_waddr, ram_raddr, ram_q;
    logic       ram_q_vld;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
            ram_waddr <= '0; ram_raddr <= '0; ram_q <= '0; ram_q_vld <= 1'b0;
        end else begin
            ram_q_vld <= 1'b0;
            if (ram_rx_valid) begin
                case (ram_din[9:8])
                    2'b00: ram_waddr <= ram_din[7:0];
                    2'b01: ram_mem[ram_waddr] <= ram_din[7:0];
                    2'b10: ram_raddr <= ram_din[7:0];
                    default: begin ram_q <= ram_mem[ram_raddr]; ram_q_vld <= 1'b1; end
                endcase
            end
        end
    end
    assign ram_dout     = ram_q;
    assign ram_tx_valid = ram_q_vld & ~suppress_tx;

    typedef struct { bit wr; logic [7:0] addr; logic [7:0] data; } txn_t;
    typedef struct { bit vld; logic [9:0] din; bit rwait; } beat_t;

    txn_t  rq0[$], rq1[$];
    beat_t cmdq[$];
    bit         m_ptr, m_err, m_wc_v, m_rc_v, rsp_pending;
    logic [7:0] m_wc, m_rc, rsp_data;
    logic [7:0] m_mem [256];
    logic [1:0] rsp_mask;
    int         rsp_cnt;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int act_cmd[$], act_acc_id[$], act_acc_cyc[$], act_rsp_cyc[$], act_rsp_mask[$], act_rsp_data[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] grant_of(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Model reaction to an accepted transaction: command beats, memory, response.
    task automatic model_accept(input bit id);
        bit wr, hit;
        logic [7:0] a, d;
        wr = req_wr[id];
        a  = id ? req_addr[15:8]  : req_addr[7:0];
        d  = id ? req_wdata[15:8] : req_wdata[7:0];
        m_ptr = ~id;
        if (wr) begin
            if (!(CACHE && m_wc_v && m_wc == a)) begin
                cmdq.push_back('{1'b1, {2'b00, a}, 1'b0});
                m_wc_v = 1'b1; m_wc = a;
            end
            cmdq.push_back('{1'b1, {2'b01, d}, 1'b0});
            m_mem[a] = d;
        end else begin
            hit = CACHE && m_rc_v && m_rc == a;
            if (!hit) begin
                cmdq.push_back('{1'b1, {2'b10, a}, 1'b0});
                m_rc_v = 1'b1; m_rc = a;
            end
            cmdq.push_back('{1'b1, 10'h300, 1'b0});
            cmdq.push_back('{1'b0, 10'h000, 1'b1});
            rsp_pending = 1'b1;
            rsp_cnt     = hit ? 3 : 4;
            rsp_mask    = id ? 2'b10 : 2'b01;
            rsp_data    = m_mem[a];
        end
    endtask

    // Requesters hold their head transaction until the DUT accepts it.
    always @(posedge clk) begin
        #1;
        req_valid[0] = (rq0.size() != 0);
        if (rq0.size() != 0) begin
            req_wr[0] = rq0[0].wr; req_addr[7:0] = rq0[0].addr; req_wdata[7:0] = rq0[0].data;
        end
        req_valid[1] = (rq1.size() != 0);
        if (rq1.size() != 0) begin
            req_wr[1] = rq1[0].wr; req_addr[15:8] = rq1[0].addr; req_wdata[15:8] = rq1[0].data;
        end
    end

    // Per-cycle compare against the model, plus logging of observed activity.
    always @(negedge clk) begin
        beat_t      b;
        bit         busy;
        logic [1:0] e_ready, e_rsp;
        cyc++;
        if (ram_rx_valid) act_cmd.push_back(int'(ram_din));
        if (rsp_valid != 2'b00) begin
            act_rsp_cyc.push_back(cyc);
            act_rsp_mask.push_back(int'(rsp_valid));
            act_rsp_data.push_back(int'(rsp_rdata));
        end
        if (req_valid[0] && req_ready[0]) begin
            act_acc_id.push_back(0); act_acc_cyc.push_back(cyc); void'(rq0.pop_front());
        end
        if (req_valid[1] && req_ready[1]) begin
            act_acc_id.push_back(1); act_acc_cyc.push_back(cyc); void'(rq1.pop_front());
        end
        if (!rst_n) begin
            cmdq.delete();
            m_ptr = 1'b0; m_err = 1'b0; m_wc_v = 1'b0; m_rc_v = 1'b0; rsp_pending = 1'b0;
            for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_ram_din", ram_din, 0);
            chk("rst_ram_rx_valid", ram_rx_valid, 0);
            chk("rst_protocol_err", protocol_err, 0);
        end else begin
            busy = (cmdq.size() != 0);
            if (busy) b = cmdq.pop_front();
            else      b = '{1'b0, 10'h000, 1'b0};
            e_ready = busy ? 2'b00 : grant_of(req_valid, m_ptr);
            e_rsp   = 2'b00;
            if (rsp_pending) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin e_rsp = rsp_mask; rsp_pending = 1'b0; end
            end
            chk("req_ready", req_ready, e_ready);
            chk("ram_rx_valid", ram_rx_valid, b.vld);
            chk("ram_din", ram_din, b.din);
            chk("rsp_valid", rsp_valid, e_rsp);
            if (e_rsp != 2'b00) chk("rsp_rdata", rsp_rdata, rsp_data);
            chk("protocol_err", protocol_err, m_err);
            if (b.rwait && !ram_tx_valid) m_err = 1'b1;
            if (e_ready != 2'b00) model_accept(e_ready[1]);
        end
    end

    task automatic clear_logs();
        act_cmd.delete(); act_acc_id.delete(); act_acc_cyc.delete();
        act_rsp_cyc.delete(); act_rsp_mask.delete(); act_rsp_data.delete();
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || cmdq.size() != 0 || rsp_pending) && n < maxc) begin
            @(negedge clk); #1; n++;
        end
        chk("idle_timeout", (n >= maxc), 0);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // Write/read round trip
        clear_logs();
        rq0.push_back('{1'b1, 8'h12, 8'hA5}); wait_idle(50);
        rq1.push_back('{1'b0, 8'h12, 8'h00}); wait_idle(50);
        chk("rt_cmd_count", act_cmd.size(), 4);
        if (act_cmd.size() >= 4) begin
            chk("rt_cmd0", act_cmd[0], 32'h012); chk("rt_cmd1", act_cmd[1], 32'h1A5);
            chk("rt_cmd2", act_cmd[2], 32'h212); chk("rt_cmd3", act_cmd[3], 32'h300);
        end
        chk("rt_rsp_count", act_rsp_cyc.size(), 1);
        if (act_rsp_cyc.size() >= 1 && act_acc_cyc.size() >= 2) begin
            chk("rt_rsp_latency", act_rsp_cyc[0] - act_acc_cyc[1], 4);
            chk("rt_rsp_mask", act_rsp_mask[0], 2);
            chk("rt_rsp_data", act_rsp_data[0], 32'hA5);
        end

        // Arbitration from reset, both requesters reading continuously
        do_reset(); clear_logs();
        rq0.push_back('{1'b0, 8'h20, 8'h00}); rq0.push_back('{1'b0, 8'h22, 8'h00});
        rq1.push_back('{1'b0, 8'h21, 8'h00}); rq1.push_back('{1'b0, 8'h23, 8'h00});
        wait_idle(100);
        chk("arb_acc_count", act_acc_id.size(), 4);
        if (act_acc_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("arb_order", act_acc_id[i], i % 2);
            for (int i = 0; i < 3; i++) chk("arb_spacing", act_acc_cyc[i+1] - act_acc_cyc[i], 4);
        end

        // Back-to-back writes, then readback
        clear_logs();
        for (int i = 0; i < 4; i++) rq0.push_back('{1'b1, 8'(i), 8'(8'h50 + i)});
        wait_idle(100);
        chk("tp_acc_count", act_acc_cyc.size(), 4);
        if (act_acc_cyc.size() >= 4)
            for (int i = 0; i < 3; i++) chk("tp_spacing", act_acc_cyc[i+1] - act_acc_cyc[i], 3);
        clear_logs();
        for (int i = 0; i < 4; i++) rq0.push_back('{1'b0, 8'(i), 8'h00});
        wait_idle(100);
        chk("tp_rsp_count", act_rsp_data.size(), 4);
        if (act_rsp_data.size() >= 4)
            for (int i = 0; i < 4; i++) chk("tp_readback", act_rsp_data[i], 32'h50 + i);

        // Protocol error: RAM valid withheld during the wait cycle
        clear_logs();
        suppress_tx = 1'b1;
        rq1.push_back('{1'b0, 8'h02, 8'h00}); wait_idle(50);
        suppress_tx = 1'b0;
        chk("perr_set", protocol_err, 1);
        chk("perr_rsp_count", act_rsp_mask.size(), 1);
        if (act_rsp_mask.size() >= 1) begin
            chk("perr_rsp_mask", act_rsp_mask[0], 2);
            chk("perr_rsp_data", act_rsp_data[0], 32'h52);
        end
        rq0.push_back('{1'b0, 8'h03, 8'h00}); wait_idle(50);
        chk("perr_sticky", protocol_err, 1);

        // Reset while the read is in its wait cycle
        clear_logs();
        rq0.push_back('{1'b0, 8'h01, 8'h00});
        n = 0;
        while (!(cmdq.size() == 1 && cmdq[0].rwait) && n < 30) begin @(negedge clk); #1; n++; end
        chk("mr_reach_rwait_timeout", (n >= 30), 0);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_ram_rx_valid", ram_rx_valid, 0);
        chk("mr_protocol_err", protocol_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk); #1;
        chk("mr_no_stale_rsp", act_rsp_cyc.size(), 0);
        clear_logs();
        rq0.push_back('{1'b0, 8'h05, 8'h00}); wait_idle(50);
        chk("mr_rsp_count", act_rsp_cyc.size(), 1);
        if (act_rsp_cyc.size() >= 1 && act_acc_cyc.size() >= 1) begin
            chk("mr_rsp_latency", act_rsp_cyc[0] - act_acc_cyc[0], 4);
            chk("mr_rsp_data", act_rsp_data[0], 0);
        end

        // Repeated address: cache behaviour depends on the build
        do_reset(); clear_logs();
        rq0.push_back('{1'b1, 8'h40, 8'h11}); rq0.push_back('{1'b1, 8'h40, 8'h22});
        wait_idle(50);
`ifdef ARB_ADDR_CACHE_EN
        chk("ac_cmd_count", act_cmd.size(), 3);
        if (act_cmd.size() >= 3) begin
            chk("ac_cmd0", act_cmd[0], 32'h040); chk("ac_cmd1", act_cmd[1], 32'h111);
            chk("ac_cmd2", act_cmd[2], 32'h122);
        end
        if (act_acc_cyc.size() >= 2) chk("ac_spacing", act_acc_cyc[1] - act_acc_cyc[0], 3);
`else
        chk("ac_cmd_count", act_cmd.size(), 4);
        if (act_cmd.size() >= 4) begin
            chk("ac_cmd0", act_cmd[0], 32'h040); chk("ac_cmd1", act_cmd[1], 32'h111);
            chk("ac_cmd2", act_cmd[2], 32'h040); chk("ac_cmd3", act_cmd[3], 32'h122);
        end
        if (act_acc_cyc.size() >= 2) chk("ac_spacing", act_acc_cyc[1] - act_acc_cyc[0], 3);
`endif
        clear_logs();
        rq0.push_back('{1'b0, 8'h40, 8'h00}); rq0.push_back('{1'b0, 8'h40, 8'h00});
        wait_idle(50);
        chk("ac_rsp_count", act_rsp_data.size(), 2);
        if (act_rsp_data.size() >= 2 && act_acc_cyc.size() >= 2) begin
            chk("ac_rd_data0", act_rsp_data[0], 32'h22);
            chk("ac_rd_data1", act_rsp_data[1], 32'h22);
`ifdef ARB_ADDR_CACHE_EN
            chk("ac_rd_latency", act_rsp_cyc[1] - act_acc_cyc[1], 3);
`else
            chk("ac_rd_latency", act_rsp_cyc[1] - act_acc_cyc[1], 4);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_cmd_arbiter.md
# ram_cmd_arbiter

Two-requester round-robin arbiter and command sequencer in front of the SPI-side single-port RAM. Each requester issues whole word transactions: write (address + data) or read (address). The block serialises them into the RAM's 2-bit-opcode command stream (00 set write address, 01 write data, 10 set read address, 11 read). It also captures the read result and returns it to the owning requester.

## Interface
Parameters:
- ADDR_SIZE, 8, RAM address and data width; RAM command word is ADDR_SIZE+2 bits
- NUM_REQ, 2, number of requesters; fixed at 2, not generic

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester transaction request
- req_ready  out  2  one-hot acceptance strobe
- req_wr  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_SIZE  requester i at [i*ADDR_SIZE +: ADDR_SIZE]
- req_wdata  in  2*ADDR_SIZE  write data, same packing
- rsp_valid  out  2  one-cycle read-response pulse to the owning requester
- rsp_rdata  out  ADDR_SIZE  shared read data, qualified by rsp_valid
- ram_din  out  ADDR_SIZE+2  {opcode[1:0], payload}
- ram_rx_valid  out  1  command strobe
- ram_dout  in  ADDR_SIZE  RAM read data
- ram_tx_valid  in  1  RAM read-data valid
- protocol_err  out  1  sticky error flag

## Operation
FSM states: IDLE, WADDR, WDATA, RADDR, RCMD, RWAIT.

Request acceptance:
- req_ready[i] = (state==IDLE) & grant[i].
- Acceptance occurs when req_valid[i] & req_ready[i].
- On acceptance, req_wr, addr and wdata are captured, along with owner id.
- Requesters hold req_valid and fields stable until accepted.

Arbitration:
- Round-robin pointer, reset value 0.
- A lone requester is always granted.
- When both request, the pointer side is granted.
- After any grant, the pointer moves to the other requester.

Transaction sequences:
- Write: IDLE → WADDR (ram_din={00,addr}) → WDATA ({01,wdata}) → IDLE.
- Read: IDLE → RADDR ({10,addr}) → RCMD ({11,0}) → RWAIT → IDLE.

Command outputs:
- ram_rx_valid=1 exactly in WADDR, WDATA, RADDR and RCMD.
- ram_din is 0 when ram_rx_valid=0.
- ram_din and ram_rx_valid decode only from state and captured registers; no combinational path from req_*.

Read-data capture:
- In RWAIT the block registers rsp_rdata<=ram_dout and rsp_valid[owner]<=1 (one-cycle pulse).
- There is no response backpressure.
- If ram_tx_valid=0 in RWAIT, protocol_err is set (sticky until reset); the response is still issued.

Reset:
- Every output resets to 0, state to IDLE, pointer to 0.
- Reset mid-transaction drops it with no response. The RAM shares rst_n, so the RAM state is reset too.

## Timing
Cycle 0 is the acceptance cycle.

Write:
- Commands on cycles 1 and 2.
- Next acceptance possible on cycle 3.
- Throughput: 3 cycles per write.

Read:
- Commands on cycles 1 and 2.
- RWAIT on cycle 3, with ram_dout valid.
- rsp_valid on cycle 4; next acceptance also possible on cycle 4.
- Throughput: 4 cycles per read.

Other rules:
- req_valid arriving while the FSM is busy waits; grant is evaluated only in IDLE.
- Simultaneous arrival is resolved by the pointer only.

## Configuration
ARB_ADDR_CACHE_EN:

Defined:
- The block keeps last_wr_addr/last_rd_addr with valid bits, cleared on reset.
- A write whose address matches a valid last_wr_addr skips WADDR (IDLE→WDATA; 2-cycle write).
- A read matching a valid last_rd_addr skips RADDR (IDLE→RCMD; rsp_valid on cycle 3).
- Each issued 00/10 command updates the corresponding cache.

Undefined:
- Address commands are always issued; timing is as above.

## Test plan
- Write/read round trip:
  - Stimulus: r0 writes addr 0x12 data 0xA5, then r1 reads 0x12.
  - ram_din sequence: 0x012, 0x1A5, 0x212, 0x300.
  - Response: rsp_valid=2'b10 four cycles after read acceptance, rsp_rdata=0xA5.
- Arbitration: both requesters hold req_valid with reads from reset → grants alternate r0, r1, r0, r1, one acceptance every 4 cycles.
- Throughput: r0 back-to-back writes to 0x00..0x03 → acceptances spaced exactly 3 cycles; readback returns the written data.
- Mid-transaction reset: rst_n pulsed low during RWAIT → rsp_valid stays 0 and all outputs are 0. After release, a read of 0x05 returns 0x00 in the cycle-4 response, with no stale response.
- Protocol error: hold ram_tx_valid=0 during RWAIT → protocol_err=1 and stays high until reset; rsp_valid still pulses.
- Address cache:
  - Stimulus: with ARB_ADDR_CACHE_EN, two writes to 0x40.
  - The second write emits only 0x1xx and takes 2 cycles.
  - Without the macro, both writes emit 0x040.
